// File: rtl/cpu_test_checker.sv
// rtl/cpu_test_checker.sv - Runs a CPU until it halts or hangs, then checks its register snapshot against expected values
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset back to IDLE
//   start             one-cycle pulse that begins a run (ignored while busy)
//   regs_debug        32 x 32-bit register file snapshot from the CPU
//   pc_debug          CPU program counter
//   end_pc/end_pc_en  optional explicit halt address
//   exp_idx/exp_val   packed register indices (5 bits each) and expected values (32 bits each)
//   busy/done         run-or-check in progress / results valid
//   pass, timed_out   overall verdict and hang indication
//   fail_mask         one bit per failing check
//   first_fail(_got)  lowest failing check index (all-ones if none) and the value seen there
//   cycle_count       RUN cycles elapsed, saturating at TIMEOUT_CYCLES
module cpu_test_checker #(
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STABLE_CYCLES  = 4,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [31:0]                       regs_debug [0:31],
    input  logic [31:0]                       pc_debug,
    input  logic [31:0]                       end_pc,
    input  logic                              end_pc_en,
    input  logic [NUM_CHECKS*5-1:0]           exp_idx,
    input  logic [NUM_CHECKS*32-1:0]          exp_val,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              timed_out,
    output logic [NUM_CHECKS-1:0]             fail_mask,
    output logic [$clog2(NUM_CHECKS):0]       first_fail,
    output logic [31:0]                       first_fail_got,
    output logic [CNT_W-1:0]                  cycle_count
);

    localparam int FF_W = $clog2(NUM_CHECKS) + 1;
    localparam int ST_W = $clog2(STABLE_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t            state, state_next;
    logic [ST_W-1:0]   stable_cnt;
    logic [31:0]       prev_pc;
    logic [FF_W-1:0]   check_idx;

    logic              halt;
    logic              tmo;
    logic              last_check;
    logic              mismatch;
    logic [4:0]        cur_idx;
    logic [31:0]       cur_exp;
    logic [31:0]       cur_got;
    logic [NUM_CHECKS-1:0] cur_sel;
    logic [NUM_CHECKS-1:0] fail_mask_next;

    assign halt       = (end_pc_en && (pc_debug == end_pc)) ||
                        (stable_cnt == ST_W'(STABLE_CYCLES - 1));
    assign tmo        = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign last_check = (check_idx == FF_W'(NUM_CHECKS - 1));

    // Select the index/expected pair for the check being performed this cycle.
    always_comb begin
        cur_idx = '0;
        cur_exp = '0;
        cur_sel = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (check_idx == FF_W'(i)) begin
                cur_idx    = exp_idx[i*5 +: 5];
                cur_exp    = exp_val[i*32 +: 32];
                cur_sel[i] = 1'b1;
            end
        end
    end

    assign cur_got        = regs_debug[cur_idx];
    assign mismatch       = (cur_got != cur_exp);
    // Includes the current check so the verdict taken on the last check sees it.
    assign fail_mask_next = mismatch ? (fail_mask | cur_sel) : fail_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                // A halt seen on the final allowed cycle still wins over the timeout.
                if (halt)     state_next = S_CHECK;
                else if (tmo) state_next = S_DONE;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (last_check) state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_next = S_RUN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count    <= '0;
            stable_cnt     <= '0;
            prev_pc        <= '0;
            check_idx      <= '0;
            fail_mask      <= '0;
            first_fail     <= '1;
            first_fail_got <= '0;
            timed_out      <= 1'b0;
            pass           <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cycle_count    <= '0;
                        stable_cnt     <= '0;
                        prev_pc        <= pc_debug;
                        check_idx      <= '0;
                        fail_mask      <= '0;
                        first_fail     <= '1;
                        first_fail_got <= '0;
                        timed_out      <= 1'b0;
                        pass           <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (cycle_count != CNT_W'(TIMEOUT_CYCLES)) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                    prev_pc    <= pc_debug;
                    stable_cnt <= (pc_debug == prev_pc) ? stable_cnt + ST_W'(1) : '0;
                    if (!halt && tmo) begin
                        timed_out <= 1'b1;
                        pass      <= 1'b0;
                    end
                end
                S_CHECK: begin
                    check_idx <= check_idx + FF_W'(1);
                    fail_mask <= fail_mask_next;
                    if (mismatch && (first_fail == '1)) begin
                        first_fail     <= check_idx;
                        first_fail_got <= cur_got;
                    end
                    if (last_check) begin
                        pass <= (fail_mask_next == '0) && !timed_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cpu_test_checker.md
CPU_TEST_CHECKER -- requirements
Module: cpu_test_checker

Interface
REQ-001 Parameter NUM_CHECKS, 4: number of register checks performed per run (1..32).
REQ-002 Parameter TIMEOUT_CYCLES, 1024: maximum RUN cycles before the run is declared hung.
REQ-003 Parameter STABLE_CYCLES, 4: number of consecutive cycles with unchanged pc_debug that counts as a halt (>=2).
REQ-004 Parameter CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the cycle counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state.
REQ-007 start  input  1  single-cycle pulse; begins a run.
REQ-008 regs_debug  input  32x32 unpacked  CPU register file snapshot.
REQ-009 pc_debug  input  32  CPU program counter.
REQ-010 end_pc  input  32  explicit halt address.
REQ-011 end_pc_en  input  1  enables end_pc halt detection.
REQ-012 exp_idx  input  NUM_CHECKS*5  packed register indices; check i uses bits [5i+4:5i].
REQ-013 exp_val  input  NUM_CHECKS*32  packed expected values; check i uses bits [32i+31:32i].
REQ-014 busy  output  1  high in RUN or CHECK.
REQ-015 done  output  1  high in DONE.
REQ-016 pass  output  1  valid when done; 1 = no timeout and all checks matched.
REQ-017 timed_out  output  1  valid when done; run hit TIMEOUT_CYCLES.
REQ-018 fail_mask  output  NUM_CHECKS  bit i set = check i mismatched.
REQ-019 first_fail  output  $clog2(NUM_CHECKS)+1  lowest failing index; all-ones when none.
REQ-020 first_fail_got  output  32  register value observed at first_fail.
REQ-021 cycle_count  output  CNT_W  RUN cycles elapsed, saturating at TIMEOUT_CYCLES.

Function
REQ-022 FSM states: IDLE, RUN, CHECK, DONE; encoding is implementation-defined.
REQ-023 IDLE: start=1 -> RUN next cycle; cycle_count, stable counter, fail_mask, timed_out cleared; first_fail set to all-ones.
REQ-024 RUN: cycle_count increments by 1 each cycle.
REQ-025 RUN: the stable counter increments when pc_debug equals the previous-cycle pc_debug and resets to 0 otherwise; its previous-PC register is loaded on entry to RUN.
REQ-026 RUN halt: (end_pc_en && pc_debug==end_pc) or stable counter reaching STABLE_CYCLES-1 -> CHECK next cycle.
REQ-027 RUN timeout: cycle_count == TIMEOUT_CYCLES-1 with no halt -> DONE next cycle with timed_out=1, pass=0, and no checks performed.
REQ-028 Halt and timeout detected in the same cycle: halt takes priority and the FSM goes to CHECK.
REQ-029 CHECK: one check per cycle, index 0 to NUM_CHECKS-1; CHECK lasts exactly NUM_CHECKS cycles.
REQ-030 CHECK: each check compares regs_debug[exp_idx_i] against exp_val_i; on mismatch set fail_mask[i], and if first_fail is all-ones, latch i and the observed value.
REQ-031 After the last check -> DONE; pass = (fail_mask==0) && !timed_out, registered on DONE entry.
REQ-032 DONE: all results held stable; start=1 -> RUN with results cleared as in REQ-023.
REQ-033 start in RUN or CHECK is ignored.
REQ-034 exp_idx=0 compares against regs_debug[0]; there is no special case for $zero.
REQ-035 Latency from halt detection to done: NUM_CHECKS+1 cycles.

Reset
REQ-036 reset=1 forces IDLE immediately, without waiting for a clock edge, and works from any state, including mid-RUN and mid-CHECK.
REQ-037 Reset values: busy=0, done=0, pass=0, timed_out=0, fail_mask=0, first_fail=all-ones, first_fail_got=0, cycle_count=0.
REQ-038 After reset deasserts, the block stays in IDLE until start.

Verification
REQ-039 NUM_CHECKS=4; regs 8..11 = 8,7,F,1 matching expectations; PC stalls at 0x54 -> done, pass=1, fail_mask=0000, first_fail=all-ones.
REQ-040 Same as REQ-039 but reg 10=0xE -> pass=0, fail_mask=0100, first_fail=2, first_fail_got=0xE.
REQ-041 PC increments forever, end_pc_en=0, TIMEOUT_CYCLES=64 -> done after 64 RUN cycles, timed_out=1, pass=0, cycle_count=64.
REQ-042 end_pc_en=1, end_pc=0x20; PC reaches 0x20 -> CHECK the next cycle; done exactly NUM_CHECKS+1 cycles after the match.
REQ-043 Assert reset during the CHECK index-2 cycle -> outputs equal reset values immediately; a new start runs to a correct pass.
REQ-044 Halt and timeout in the same cycle (TIMEOUT_CYCLES=8, PC stalls so the halt fires at cycle 7) -> CHECK is entered and timed_out=0.
